simd_alu64_part: RTL and testbench



---
 rtl/simd_alu64_part.sv | 205 ++++++++++++++++++++
 tb/tb_simd_alu64_part.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/simd_alu64_part.sv
// simd_alu64_part: registered 64-bit partitioned ALU built from four 16-bit lanes.
// Performs add, subtract or XOR as 1x64, 2x32 or 4x16 operations; results are
// registered, so they appear one clock after the operands are applied.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset, clears all results
//   mc[2:0]        mode: 111 = 1x64, 110 = 2x32, 100 = 4x16, others hold outputs
//   op[1:0]        00 = A-B, 01/10 = A+B, 11 = A^B
//   word1..word4   operand A lanes 0..3 (A = {word4,word3,word2,word1})
//   word31..word34 operand B lanes 0..3 (B = {word34,word33,word32,word31})
//   res1[63:0]     64-bit result / low 32-bit result / lane-0 result
//   res2[31:0]     high 32-bit result / lane-1 result
//   res3[15:0]     lane-2 result
//   res4[15:0]     lane-3 result

// 4-bit carry-lookahead group: sum plus group generate/propagate for the
// second-level lookahead.
module simd_alu64_part_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    sum  = p ^ c;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp   = &p;
  end

endmodule

// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead unit
// producing the group carries and the carry-out.
module simd_alu64_part_cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  // Group signals are kept as scalars so the lookahead path has no
  // vector-level feedback between the groups.
  logic gg0, gg1, gg2, gg3;
  logic gp0, gp1, gp2, gp3;
  logic c4, c8, c12;

  assign c4   = gg0 | (gp0 & cin);
  assign c8   = gg1 | (gp1 & gg0) | (gp1 & gp0 & cin);
  assign c12  = gg2 | (gp2 & gg1) | (gp2 & gp1 & gg0) | (gp2 & gp1 & gp0 & cin);
  assign cout = gg3 | (gp3 & gg2) | (gp3 & gp2 & gg1) | (gp3 & gp2 & gp1 & gg0)
              | (gp3 & gp2 & gp1 & gp0 & cin);

  simd_alu64_part_cla4 u_grp0 (
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .sum(sum[3:0]), .gg(gg0), .gp(gp0)
  );
  simd_alu64_part_cla4 u_grp1 (
    .a(a[7:4]), .b(b[7:4]), .cin(c4), .sum(sum[7:4]), .gg(gg1), .gp(gp1)
  );
  simd_alu64_part_cla4 u_grp2 (
    .a(a[11:8]), .b(b[11:8]), .cin(c8), .sum(sum[11:8]), .gg(gg2), .gp(gp2)
  );
  simd_alu64_part_cla4 u_grp3 (
    .a(a[15:12]), .b(b[15:12]), .cin(c12), .sum(sum[15:12]), .gg(gg3), .gp(gp3)
  );

endmodule

module simd_alu64_part #(
  parameter int unsigned LANE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            mc,
  input  logic [1:0]            op,
  input  logic [LANE_W-1:0]     word1,
  input  logic [LANE_W-1:0]     word2,
  input  logic [LANE_W-1:0]     word3,
  input  logic [LANE_W-1:0]     word4,
  input  logic [LANE_W-1:0]     word31,
  input  logic [LANE_W-1:0]     word32,
  input  logic [LANE_W-1:0]     word33,
  input  logic [LANE_W-1:0]     word34,
  output logic [4*LANE_W-1:0]   res1,
  output logic [2*LANE_W-1:0]   res2,
  output logic [LANE_W-1:0]     res3,
  output logic [LANE_W-1:0]     res4
);

  typedef enum logic [2:0] {
    MODE_64 = 3'b111,
    MODE_32 = 3'b110,
    MODE_16 = 3'b100
  } mode_e;

  mode_e mode;
  logic  is_sub;
  logic  is_xor;

  assign mode   = mode_e'(mc);
  assign is_sub = (op == 2'b00);
  assign is_xor = (op == 2'b11);

  // Subtract is A + ~B + 1; the +1 enters wherever a partition starts,
  // i.e. on every lane whose inter-lane carry is gated off by mc.
  logic [LANE_W-1:0] b0, b1, b2, b3;
  assign b0 = word31 ^ {LANE_W{is_sub}};
  assign b1 = word32 ^ {LANE_W{is_sub}};
  assign b2 = word33 ^ {LANE_W{is_sub}};
  assign b3 = word34 ^ {LANE_W{is_sub}};

  logic ci1, ci2, ci3;
  logic co0, co1, co2;
  logic unused_co3;

  assign ci1 = mc[1] ? co0 : is_sub;
  assign ci2 = mc[0] ? co1 : is_sub;
  assign ci3 = mc[1] ? co2 : is_sub;

  logic [LANE_W-1:0] s0, s1, s2, s3;

  simd_alu64_part_cla16 u_lane0 (
    .a(word1), .b(b0), .cin(is_sub), .sum(s0), .cout(co0)
  );
  simd_alu64_part_cla16 u_lane1 (
    .a(word2), .b(b1), .cin(ci1), .sum(s1), .cout(co1)
  );
  simd_alu64_part_cla16 u_lane2 (
    .a(word3), .b(b2), .cin(ci2), .sum(s2), .cout(co2)
  );
  // Final carry of the top lane is dropped: results are modulo 2^width.
  simd_alu64_part_cla16 u_lane3 (
    .a(word4), .b(b3), .cin(ci3), .sum(s3), .cout(unused_co3)
  );

  // Lane-wise XOR arrays; mode only affects packing.
  logic [LANE_W-1:0] x0, x1, x2, x3;
  assign x0 = word1 ^ word31;
  assign x1 = word2 ^ word32;
  assign x2 = word3 ^ word33;
  assign x3 = word4 ^ word34;

  logic [LANE_W-1:0] r0, r1, r2, r3;
  assign r0 = is_xor ? x0 : s0;
  assign r1 = is_xor ? x1 : s1;
  assign r2 = is_xor ? x2 : s2;
  assign r3 = is_xor ? x3 : s3;

  logic [4*LANE_W-1:0] nxt1;
  logic [2*LANE_W-1:0] nxt2;
  logic [LANE_W-1:0]   nxt3;
  logic [LANE_W-1:0]   nxt4;
  logic                mode_ok;

  always_comb begin
    nxt1    = '0;
    nxt2    = '0;
    nxt3    = '0;
    nxt4    = '0;
    mode_ok = 1'b1;
    case (mode)
      MODE_64: nxt1 = {r3, r2, r1, r0};
      MODE_32: begin
        nxt1 = {{(2*LANE_W){1'b0}}, r1, r0};
        nxt2 = {r3, r2};
      end
      MODE_16: begin
        nxt1 = {{(3*LANE_W){1'b0}}, r0};
        nxt2 = {{LANE_W{1'b0}}, r1};
        nxt3 = r2;
        nxt4 = r3;
      end
      default: mode_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res1 <= '0;
      res2 <= '0;
      res3 <= '0;
      res4 <= '0;
    end else if (mode_ok) begin
      res1 <= nxt1;
      res2 <= nxt2;
      res3 <= nxt3;
      res4 <= nxt4;
    end
  end

endmodule

// File: tb/tb_simd_alu64_part.sv
// Self-checking bench for simd_alu64_part: table of directed vectors plus
// hand-written sequences for reset and illegal-mode hold behaviour.
module tb_simd_alu64_part;

  logic        clk;
  logic        rst_n;
  logic [2:0]  mc;
  logic [1:0]  op;
  logic [15:0] word1, word2, word3, word4;
  logic [15:0] word31, word32, word33, word34;
  logic [63:0] res1;
  logic [31:0] res2;
  logic [15:0] res3, res4;

  int total;
  int bad;

  simd_alu64_part #(.LANE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mc(mc), .op(op),
    .word1(word1), .word2(word2), .word3(word3), .word4(word4),
    .word31(word31), .word32(word32), .word33(word33), .word34(word34),
    .res1(res1), .res2(res2), .res3(res3), .res4(res4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mc;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e1;
    logic [31:0] e2;
    logic [15:0] e3;
    logic [15:0] e4;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int idx,
                       input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(input string name, input int idx,
                           input logic [63:0] e1, input logic [31:0] e2,
                           input logic [15:0] e3, input logic [15:0] e4);
    check({name, ".res1"}, idx, res1, e1);
    check({name, ".res2"}, idx, {32'h0, res2}, {32'h0, e2});
    check({name, ".res3"}, idx, {48'h0, res3}, {48'h0, e3});
    check({name, ".res4"}, idx, {48'h0, res4}, {48'h0, e4});
  endtask

  task automatic drive(input logic [2:0] m, input logic [1:0] o,
                       input logic [63:0] a, input logic [63:0] b);
    mc     = m;
    op     = o;
    word1  = a[15:0];
    word2  = a[31:16];
    word3  = a[47:32];
    word4  = a[63:48];
    word31 = b[15:0];
    word32 = b[31:16];
    word33 = b[47:32];
    word34 = b[63:48];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //                 mc      op     A                      B                      res1                   res2          res3     res4
    vecs[0]  = '{3'b111, 2'b01, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 64'h0001_0000_0000_0000, 32'h0,        16'h0,   16'h0};
    vecs[1]  = '{3'b110, 2'b10, 64'h0000_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 64'h0000_0000_0000_0000, 32'h0001_0000, 16'h0,   16'h0};
    vecs[2]  = '{3'b100, 2'b00, 64'h1234_8000_0000_0005, 64'h0234_8000_0001_0003, 64'h0000_0000_0000_0002, 32'h0000_FFFF, 16'h0,   16'h1000};
    vecs[3]  = '{3'b111, 2'b00, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0,        16'h0,   16'h0};
    vecs[4]  = '{3'b111, 2'b11, 64'h0000_FFFF_5555_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_0000_AAAA_5555, 32'h0,        16'h0,   16'h0};
    vecs[5]  = '{3'b110, 2'b00, 64'h0000_0000_0000_0000, 64'h0000_0001_0000_0001, 64'h0000_0000_FFFF_FFFF, 32'hFFFF_FFFF, 16'h0,   16'h0};
    vecs[6]  = '{3'b100, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0001_0001_0001_0001, 64'h0,                   32'h0,        16'h0,   16'h0};
    vecs[7]  = '{3'b100, 2'b11, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_0000_DEF0, 32'h0000_6543, 16'h5678, 16'hEDCB};
    vecs[8]  = '{3'b111, 2'b10, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 64'h1234_5678_9ABC_DF00, 32'h0,        16'h0,   16'h0};
    vecs[9]  = '{3'b110, 2'b00, 64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0,                   32'h7FFF_FFFF, 16'h0,   16'h0};
    vecs[10] = '{3'b111, 2'b00, 64'h0001_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_FFFF_FFFF_FFFF, 32'h0,        16'h0,   16'h0};
    vecs[11] = '{3'b100, 2'b10, 64'h7FFF_FFFF_0001_8000, 64'h0001_0001_FFFF_8000, 64'h0,                   32'h0,        16'h0,   16'h8000};

    // Reset asserted between edges clears outputs without a clock.
    rst_n = 1'b1;
    drive(3'b111, 2'b01, 64'h0, 64'h0);
    #1 rst_n = 1'b0;
    #1;
    check_all("reset_async", 0, 64'h0, 32'h0, 16'h0, 16'h0);

    // Held reset across an edge with live operands keeps outputs at zero.
    @(negedge clk);
    drive(vecs[0].mc, vecs[0].op, vecs[0].a, vecs[0].b);
    step();
    check_all("reset_held", 0, 64'h0, 32'h0, 16'h0, 16'h0);

    // Release between edges: still zero until the next edge, then updates.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all("reset_release", 0, 64'h0, 32'h0, 16'h0, 16'h0);
    step();
    check_all("first_edge", 0, vecs[0].e1, vecs[0].e2, vecs[0].e3, vecs[0].e4);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vecs[i].mc, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check_all("vec", i, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4);
    end

    // Illegal modes hold the previous registered result.
    @(negedge clk);
    drive(vecs[4].mc, vecs[4].op, vecs[4].a, vecs[4].b);
    step();
    check_all("xor_load", 0, vecs[4].e1, vecs[4].e2, vecs[4].e3, vecs[4].e4);
    @(negedge clk);
    drive(3'b101, 2'b01, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101);
    step();
    step();
    check_all("illegal_hold", 101, vecs[4].e1, vecs[4].e2, vecs[4].e3, vecs[4].e4);
    @(negedge clk);
    drive(3'b000, 2'b00, 64'h0, 64'h5);
    step();
    check_all("illegal_hold", 0, vecs[4].e1, vecs[4].e2, vecs[4].e3, vecs[4].e4);
    @(negedge clk);
    drive(3'b011, 2'b11, 64'hFFFF, 64'h0);
    step();
    check_all("illegal_hold", 11, vecs[4].e1, vecs[4].e2, vecs[4].e3, vecs[4].e4);

    // Legal mode resumes updating after an illegal stretch.
    @(negedge clk);
    drive(vecs[7].mc, vecs[7].op, vecs[7].a, vecs[7].b);
    step();
    check_all("resume", 7, vecs[7].e1, vecs[7].e2, vecs[7].e3, vecs[7].e4);

    // Mid-cycle reset with a pending operation discards it.
    @(negedge clk);
    drive(vecs[2].mc, vecs[2].op, vecs[2].a, vecs[2].b);
    #2 rst_n = 1'b0;
    #1;
    check_all("reset_midop", 0, 64'h0, 32'h0, 16'h0, 16'h0);
    step();
    check_all("reset_midop_edge", 0, 64'h0, 32'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_all("after_midop", 2, vecs[2].e1, vecs[2].e2, vecs[2].e3, vecs[2].e4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
